// File: rtl/cpu_step_sequencer_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcode values,
// step encodings and PC source selects. The step-3 ALU-control decoder
// imports the same package so both blocks agree on these constants.
package cpu_step_sequencer_pkg;

    localparam logic [5:0] OPC_ADD  = 6'b000000;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;

    typedef enum logic [2:0] {
        STEP_FETCH   = 3'd1,
        STEP_DECODE  = 3'd2,
        STEP_EXEC    = 3'd3,
        STEP_MEM     = 3'd4,
        STEP_WB      = 3'd5,
        STEP_ILLEGAL = 3'd7
    } step_e;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

endpackage

// File: rtl/cpu_step_sequencer_opcode_class.sv
// Purely combinational classification of the latched opcode into the
// attributes the step sequencer branches on.
import cpu_step_sequencer_pkg::*;

module cpu_opcode_class #(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode,
    output logic             supported,
    output logic             is_mem,
    output logic             is_load,
    output logic             is_store,
    output logic             needs_wb,
    output logic             is_branch,
    output logic             is_jump,
    output logic             is_rtype
);

    // Decode the opcode into class flags; anything not listed is unsupported.
    always_comb begin
        supported = 1'b0;
        is_mem    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        needs_wb  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_rtype  = 1'b0;
        case (opcode)
            OPC_W'(OPC_ADD): begin
                supported = 1'b1;
                needs_wb  = 1'b1;
                is_rtype  = 1'b1;
            end
            OPC_W'(OPC_ADDI): begin
                supported = 1'b1;
                needs_wb  = 1'b1;
            end
            OPC_W'(OPC_LW): begin
                supported = 1'b1;
                is_mem    = 1'b1;
                is_load   = 1'b1;
                needs_wb  = 1'b1;
            end
            OPC_W'(OPC_SW): begin
                supported = 1'b1;
                is_mem    = 1'b1;
                is_store  = 1'b1;
            end
            OPC_W'(OPC_BEQ): begin
                supported = 1'b1;
                is_branch = 1'b1;
            end
            OPC_W'(OPC_J): begin
                supported = 1'b1;
                is_jump   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_step_sequencer.sv
// Multi-cycle CPU step sequencer: walks FETCH/DECODE/EXEC/MEM/WB for each
// instruction and drives the datapath strobes. Unsupported opcodes park the
// sequencer in ILLEGAL until reset.
import cpu_step_sequencer_pkg::*;

module cpu_step_sequencer #(
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] instr_opcode,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic [2:0]       step,
    output logic [OPC_W-1:0] opcode_step_3,
    output logic             ir_write,
    output logic             pc_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [1:0]       pc_src,
    output logic             illegal
);

    step_e            state_q;
    step_e            state_d;
    logic [OPC_W-1:0] opcode_q;
    logic             illegal_q;
    logic             fetch_done;

    logic supported, is_mem, is_load, is_store;
    logic needs_wb, is_branch, is_jump, is_rtype;

    cpu_opcode_class #(.OPC_W(OPC_W)) u_class (
        .opcode    (opcode_q),
        .supported (supported),
        .is_mem    (is_mem),
        .is_load   (is_load),
        .is_store  (is_store),
        .needs_wb  (needs_wb),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .is_rtype  (is_rtype)
    );

    assign fetch_done    = (state_q == STEP_FETCH) && mem_ready;
    assign step          = state_q;
    assign opcode_step_3 = opcode_q;
    assign illegal       = illegal_q;

    // State, latched opcode and sticky illegal flag; the opcode only
    // changes on an accepted fetch so step-3 decode sees a stable value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STEP_FETCH;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fetch_done) begin
                opcode_q <= instr_opcode;
            end
            if (state_d == STEP_ILLEGAL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode; reset masks every strobe at once.
    always_comb begin
        state_d    = state_q;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = PC_SRC_SEQ;
        case (state_q)
            STEP_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = STEP_DECODE;
                end
            end
            STEP_DECODE: begin
                state_d = supported ? STEP_EXEC : STEP_ILLEGAL;
            end
            STEP_EXEC: begin
                if (is_jump) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                    state_d  = STEP_FETCH;
                end else if (is_branch) begin
                    if (alu_zero) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_BRANCH;
                    end
                    state_d = STEP_FETCH;
                end else if (is_mem) begin
                    state_d = STEP_MEM;
                end else if (needs_wb) begin
                    state_d = STEP_WB;
                end else begin
                    state_d = STEP_FETCH;
                end
            end
            STEP_MEM: begin
                mem_read  = is_load;
                mem_write = is_store;
                if (mem_ready) begin
                    state_d = is_load ? STEP_WB : STEP_FETCH;
                end
            end
            STEP_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_load;
                state_d    = STEP_FETCH;
            end
            STEP_ILLEGAL: begin
                state_d = STEP_ILLEGAL;
            end
            default: begin
                state_d = STEP_FETCH;
            end
        endcase
        if (rst) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            pc_src     = PC_SRC_SEQ;
        end
    end

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Bench for cpu_step_sequencer: each instruction is expanded into an
// expected per-cycle trace from the step rules, then replayed against the DUT.
module tb_cpu_step_sequencer;

    localparam logic [5:0] ADD  = 6'b000000;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] instr_opcode = '0;
    logic       mem_ready = 1'b0;
    logic       alu_zero = 1'b0;
    logic [2:0] step;
    logic [5:0] opcode_step_3;
    logic       ir_write, pc_write, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, illegal;
    logic [1:0] pc_src;

    always #5 clk = ~clk;

    cpu_step_sequencer #(.OPC_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_opcode  (instr_opcode),
        .mem_ready     (mem_ready),
        .alu_zero      (alu_zero),
        .step          (step),
        .opcode_step_3 (opcode_step_3),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .pc_src        (pc_src),
        .illegal       (illegal)
    );

    typedef struct {
        logic        rst;
        logic        mr;
        logic        az;
        logic [5:0]  instr;
        logic [18:0] exp;
        int          id;
    } cyc_t;

    cyc_t       q[$];
    logic [5:0] lat_opc = '0;
    int         inst_no = 0;
    int         errors = 0;
    int         checks = 0;

    // Expected output vector: {step, opcode, ir, pcw, pc_src, mrd, mwr, rw, rdst, m2r, illegal}
    function automatic logic [18:0] pk(int st, logic [5:0] opc, bit ir, bit pw, logic [1:0] src,
                                       bit mr, bit mw, bit rw, bit rd, bit m2r, bit ill);
        return {3'(st), opc, ir, pw, src, mr, mw, rw, rd, m2r, ill};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic void push(logic r, logic mr, logic az, logic [5:0] instr, logic [18:0] e);
        cyc_t c;
        c.rst = r; c.mr = mr; c.az = az; c.instr = instr; c.exp = e; c.id = inst_no;
        q.push_back(c);
    endfunction

    // Expand one instruction into its cycle-by-cycle expectations.
    function automatic void plan(logic [5:0] opc, int fw, int mw, logic az, int ill_cycles);
        bit sup = opc inside {ADD, J, BEQ, ADDI, LW, SW};
        bit ld  = (opc == LW);
        bit st  = (opc == SW);
        bit tk  = (opc == BEQ) && az;
        inst_no++;
        for (int i = 0; i < fw; i++)
            push(0, 0, rb(), rop(), pk(1, lat_opc, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        push(0, 1, rb(), opc, pk(1, lat_opc, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        lat_opc = opc;
        push(0, rb(), rb(), rop(), pk(2, lat_opc, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (!sup) begin
            for (int i = 0; i < ill_cycles; i++)
                push(0, rb(), rb(), rop(), pk(7, lat_opc, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            return;
        end
        push(0, rb(), (opc == BEQ) ? az : rb(), rop(),
             pk(3, lat_opc, 0, (opc == J) || tk, (opc == J) ? 2'd2 : (tk ? 2'd1 : 2'd0),
                0, 0, 0, 0, 0, 0));
        if (ld || st) begin
            for (int i = 0; i < mw; i++)
                push(0, 0, rb(), rop(), pk(4, lat_opc, 0, 0, 0, ld, st, 0, 0, 0, 0));
            push(0, 1, rb(), rop(), pk(4, lat_opc, 0, 0, 0, ld, st, 0, 0, 0, 0));
        end
        if (opc == ADD || opc == ADDI || ld)
            push(0, rb(), rb(), rop(), pk(5, lat_opc, 0, 0, 0, 0, 0, 1, opc == ADD, ld, 0));
    endfunction

    // One reset cycle seen from the current step: no strobes, then state clears.
    function automatic void plan_rst(int cur_step, bit ill_now);
        inst_no++;
        push(1, rb(), rb(), rop(), pk(cur_step, lat_opc, 0, 0, 0, 0, 0, 0, 0, 0, ill_now));
        lat_opc = '0;
    endfunction

    // Replay n queued cycles (all if n < 0), then drop anything left over.
    task automatic run(int n);
        cyc_t        c;
        logic [18:0] obs;
        int          cnt = 0;
        while (q.size() > 0 && (n < 0 || cnt < n)) begin
            c = q.pop_front();
            cnt++;
            @(negedge clk);
            rst          = c.rst;
            mem_ready    = c.mr;
            alu_zero     = c.az;
            instr_opcode = c.instr;
            #1;
            obs = {step, opcode_step_3, ir_write, pc_write, pc_src, mem_read, mem_write,
                   reg_write, reg_dst, mem_to_reg, illegal};
            checks++;
            assert (obs === c.exp) else begin
                errors++;
                $error("FAIL instr%0d_cyc%0d observed=%05h expected=%05h", c.id, cnt, obs, c.exp);
            end
        end
        q.delete();
    endtask

    initial begin
        // Power-up reset: first edge puts the sequencer into FETCH.
        @(negedge clk);
        plan_rst(1, 0);
        run(-1);

        plan(ADD, 0, 0, 0, 0);          // 1,2,3,5 then FETCH
        plan(LW, 0, 2, 0, 0);           // MEM held 3 cycles, 7 total
        plan(BEQ, 0, 0, 1, 0);          // taken
        plan(BEQ, 0, 0, 0, 0);          // not taken
        plan(J, 0, 0, 0, 0);
        plan(SW, 0, 1, 0, 0);
        plan(ADDI, 2, 0, 0, 0);         // fetch wait
        run(-1);

        for (int i = 0; i < 30; i++) begin
            logic [5:0] o;
            case ($urandom_range(0, 5))
                0: o = ADD;
                1: o = J;
                2: o = BEQ;
                3: o = ADDI;
                4: o = LW;
                default: o = SW;
            endcase
            plan(o, $urandom_range(0, 2), $urandom_range(0, 2), rb(), 0);
        end
        run(-1);

        // Reset during a load's MEM wait: FETCH, DECODE, EXEC, MEM, MEM then rst.
        plan(LW, 0, 5, 0, 0);
        run(5);
        plan_rst(4, 0);
        plan(ADD, 1, 0, 0, 0);
        run(-1);

        // Unsupported opcode: sticks in ILLEGAL until reset.
        plan(6'b111111, 0, 0, 0, 10);
        plan_rst(7, 1);
        plan(BEQ, 0, 0, 1, 0);
        run(-1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
